theta_sequencer: RTL and testbench

Controller that sequences the theta tangent datapath over a full scan: issues one theta_iteration pulse per scan point, with POINTS_PER_LINE_P points per frame and NUMBER_OF_FRAMES_P frames. It pairs the returning 16-bit cos/sin results and buffers them in a small FIFO. It presents them to the downstream CORDIC stage over a valid/ready handshake, tagged with point and frame indices. Credit-based issue bounds the number of in-flight requests, so backpressure never loses a result.

---
 rtl/theta_seq_pkg.sv | 23 ++
 rtl/theta_pair_fifo.sv | 49 ++++
 rtl/theta_sequencer.sv | 174 +++++++++++++++++
 tb/tb_theta_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/theta_seq_pkg.sv
// Shared state, result-pair type and sizing helpers for the theta scan sequencer.
package theta_seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

   typedef struct packed {
      logic [15:0] cos;
      logic [15:0] sin;
   } pair_t;

   function automatic int pointWidth(input int points);
      return (points < 2) ? 1 : $clog2(points);
   endfunction

   function automatic int frameWidth(input int frames);
      return (frames < 2) ? 1 : $clog2(frames);
   endfunction

   function automatic int scanTotal(input int points, input int frames);
      return points * frames;
   endfunction

endpackage

// File: rtl/theta_pair_fifo.sv
// Pair FIFO (DEPTH_P x 32 flops): a push is visible at the head the next cycle, no bypass.
// Flush empties it in one cycle; a push into a full FIFO is refused unless a pop frees the slot.
module theta_pair_fifo
   import theta_seq_pkg::*;
#(
   parameter int DEPTH_P = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     pushVld,
   input  pair_t                    pushDat,
   input  logic                     popRdy,
   output logic                     popVld,
   output pair_t                    popDat,
   output logic [$clog2(DEPTH_P):0] count
);
   localparam int AW = $clog2(DEPTH_P);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH_P);

   pair_t         mem [DEPTH_P];
   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic          doPush;
   logic          doPop;

   assign popVld = (count != '0);
   assign popDat = mem[rdPtr];
   assign doPop  = popVld && popRdy;
   assign doPush = pushVld && ((count != FULL) || doPop);

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop) rdPtr <= rdPtr + 1'b1;
         count <= count + (AW + 1)'(doPush) - (AW + 1)'(doPop);
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushDat;
   end

endmodule

// File: rtl/theta_sequencer.sv
// Scan sequencer: credit-limited theta requests, cos/sin pairing, FIFO to a valid/ready output.
// A completed pair is presented one cycle later; output stalls hold data and throttle issue via credits.
module theta_sequencer
   import theta_seq_pkg::*;
#(
   parameter int POINTS_PER_LINE_P  = 360,
   parameter int NUMBER_OF_FRAMES_P = 5,
   parameter int DEPTH_P            = 4
) (
   input  logic                                        clk_i,
   input  logic                                        rst_i,
   input  logic                                        start_i,
   input  logic                                        abort_i,
   output logic                                        theta_iteration_o,
   input  logic                                        thetaCos_valid_i,
   input  logic                                        thetaSin_valid_i,
   input  logic [15:0]                                 thetaCos_i,
   input  logic [15:0]                                 thetaSin_i,
   output logic                                        out_valid_o,
   input  logic                                        out_ready_i,
   output logic [15:0]                                 out_cos_o,
   output logic [15:0]                                 out_sin_o,
   output logic [pointWidth(POINTS_PER_LINE_P)-1:0]    out_point_o,
   output logic [frameWidth(NUMBER_OF_FRAMES_P)-1:0]   out_frame_o,
   output logic                                        out_last_o,
   output logic                                        busy_o,
   output logic                                        done_o,
   output logic                                        err_o
);
   localparam int PW    = pointWidth(POINTS_PER_LINE_P);
   localparam int FW    = frameWidth(NUMBER_OF_FRAMES_P);
   localparam int TOTAL = scanTotal(POINTS_PER_LINE_P, NUMBER_OF_FRAMES_P);
   localparam int IW    = $clog2(TOTAL + 1);
   localparam int CW    = $clog2(DEPTH_P) + 1;

   localparam logic [PW-1:0] LAST_POINT = PW'(POINTS_PER_LINE_P - 1);
   localparam logic [FW-1:0] LAST_FRAME = FW'(NUMBER_OF_FRAMES_P - 1);
   localparam logic [IW-1:0] LAST_ISSUE = IW'(TOTAL - 1);
   localparam logic [CW:0]   CREDITS    = (CW + 1)'(DEPTH_P);

   state_t        state, nextState;
   logic [IW-1:0] issued;
   logic [CW-1:0] inflight, fifoCount;
   logic [CW:0]   creditUsed;
   logic          cosPend, sinPend;
   logic [15:0]   cosHeld, sinHeld;
   logic          cosErr, sinErr, cosTake, sinTake, pairDone;
   logic          startNow, abortNow, issue, push, pop, outVld;
   pair_t         pairDat, headDat;
   logic [PW-1:0] outPoint;
   logic [FW-1:0] outFrame;

   // Pair-slots already committed: requests in flight plus results waiting to leave.
   assign creditUsed = {1'b0, inflight} + {1'b0, fifoCount};

   always_comb begin
      nextState = state;
      startNow  = 1'b0;
      abortNow  = 1'b0;
      issue     = 1'b0;
      done_o    = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               nextState = RUN;
               startNow  = 1'b1;
            end
         end
         RUN: begin
            if (abort_i) begin
               nextState = FLUSH;
               abortNow  = 1'b1;
            end else if (creditUsed < CREDITS) begin
               issue = 1'b1;
               if (issued == LAST_ISSUE) nextState = DRAIN;
            end
         end
         DRAIN: begin
            if (abort_i) begin
               nextState = FLUSH;
               abortNow  = 1'b1;
            end else if (inflight == '0 && fifoCount == '0) begin
               nextState = IDLE;
               done_o    = 1'b1;
            end
         end
         FLUSH: begin
            if (inflight == '0) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // A sample is dropped if its channel already holds one or nothing is outstanding.
   assign cosErr   = thetaCos_valid_i && (cosPend || inflight == '0);
   assign sinErr   = thetaSin_valid_i && (sinPend || inflight == '0);
   assign cosTake  = thetaCos_valid_i && !cosErr;
   assign sinTake  = thetaSin_valid_i && !sinErr;
   assign pairDone = (cosPend || cosTake) && (sinPend || sinTake);
   assign pairDat  = '{cos: (cosTake ? thetaCos_i : cosHeld), sin: (sinTake ? thetaSin_i : sinHeld)};
   assign push     = pairDone && (state != FLUSH) && !abortNow;
   assign pop      = outVld && out_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         issued   <= '0;
         inflight <= '0;
         cosPend  <= 1'b0;
         sinPend  <= 1'b0;
         cosHeld  <= '0;
         sinHeld  <= '0;
         outPoint <= '0;
         outFrame <= '0;
         err_o    <= 1'b0;
      end else begin
         state    <= nextState;
         inflight <= inflight + CW'(issue) - CW'(pairDone);
         if (startNow) begin
            issued   <= '0;
            outPoint <= '0;
            outFrame <= '0;
         end else begin
            if (issue) issued <= issued + 1'b1;
            if (pop) begin
               if (outPoint == LAST_POINT) begin
                  outPoint <= '0;
                  outFrame <= outFrame + 1'b1;
               end else begin
                  outPoint <= outPoint + 1'b1;
               end
            end
         end
         if (pairDone) begin
            cosPend <= 1'b0;
            sinPend <= 1'b0;
         end else begin
            if (cosTake) begin
               cosPend <= 1'b1;
               cosHeld <= thetaCos_i;
            end
            if (sinTake) begin
               sinPend <= 1'b1;
               sinHeld <= thetaSin_i;
            end
         end
         if (cosErr || sinErr) err_o <= 1'b1;
      end
   end

   theta_pair_fifo #(
      .DEPTH_P (DEPTH_P)
   ) pairFifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .flush   (abortNow),
      .pushVld (push),
      .pushDat (pairDat),
      .popRdy  (out_ready_i),
      .popVld  (outVld),
      .popDat  (headDat),
      .count   (fifoCount)
   );

   assign theta_iteration_o = issue;
   assign busy_o            = (state != IDLE);
   assign out_valid_o       = outVld;
   assign out_cos_o         = outVld ? headDat.cos : '0;
   assign out_sin_o         = outVld ? headDat.sin : '0;
   assign out_point_o       = outPoint;
   assign out_frame_o       = outFrame;
   assign out_last_o        = outVld && (outPoint == LAST_POINT) && (outFrame == LAST_FRAME);

endmodule

// File: tb/tb_theta_sequencer.sv
// Directed + randomized bench for theta_sequencer with a queue-based responder and scoreboard.
module tb_theta_sequencer;
   localparam int P     = 4;
   localparam int F     = 2;
   localparam int D     = 4;
   localparam int TOTAL = P * F;

   logic        clk = 1'b0;
   logic        rst_i, start_i, abort_i, theta_iteration_o;
   logic        thetaCos_valid_i, thetaSin_valid_i;
   logic [15:0] thetaCos_i, thetaSin_i;
   logic        out_valid_o, out_ready_i;
   logic [15:0] out_cos_o, out_sin_o;
   logic [1:0]  out_point_o;
   logic [0:0]  out_frame_o;
   logic        out_last_o, busy_o, done_o, err_o;

   always #5 clk = ~clk;

   theta_sequencer #(
      .POINTS_PER_LINE_P  (P),
      .NUMBER_OF_FRAMES_P (F),
      .DEPTH_P            (D)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .start_i           (start_i),
      .abort_i           (abort_i),
      .theta_iteration_o (theta_iteration_o),
      .thetaCos_valid_i  (thetaCos_valid_i),
      .thetaSin_valid_i  (thetaSin_valid_i),
      .thetaCos_i        (thetaCos_i),
      .thetaSin_i        (thetaSin_i),
      .out_valid_o       (out_valid_o),
      .out_ready_i       (out_ready_i),
      .out_cos_o         (out_cos_o),
      .out_sin_o         (out_sin_o),
      .out_point_o       (out_point_o),
      .out_frame_o       (out_frame_o),
      .out_last_o        (out_last_o),
      .busy_o            (busy_o),
      .done_o            (done_o),
      .err_o             (err_o)
   );

   typedef struct {
      int          t;
      logic [15:0] v;
   } ev_t;

   typedef struct {
      logic [15:0] c;
      logic [15:0] s;
      int          idx;
   } exp_t;

   ev_t  cosQ[$];
   ev_t  sinQ[$];
   exp_t expQ[$];
   int   cyc, mode, reqIdx, lastDone, pulseCnt, outCnt, doneCnt;
   int   checks, failures;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at negedge (model + scoreboard), then drive responder just after posedge.
   // Modes: 0 = both results 3 cycles after the pulse, 1 = random split timing,
   // 2 = cos two cycles ahead of sin, 3 = no automatic responses.
   task automatic tick();
      exp_t        e;
      logic [15:0] c, s;
      int          base, ct, st;
      @(negedge clk);
      if (done_o) doneCnt++;
      if (theta_iteration_o) begin
         pulseCnt++;
         base = ((cyc + 1) > (lastDone + 1)) ? cyc + 1 : lastDone + 1;
         c    = 16'($urandom);
         s    = 16'($urandom);
         ct   = base + int'($urandom_range(2, 0));
         st   = base + int'($urandom_range(2, 0));
         if (mode == 0) begin
            ct = cyc + 3;
            st = cyc + 3;
         end else if (mode == 2) begin
            ct = base;
            st = base + 2;
            c  = 16'h1234 + 16'(reqIdx);
            s  = 16'h5678 + 16'(reqIdx);
         end
         if (mode != 3) begin
            cosQ.push_back('{ct, c});
            sinQ.push_back('{st, s});
            expQ.push_back('{c, s, reqIdx});
            lastDone = (ct > st) ? ct : st;
         end
         reqIdx++;
      end
      if (expQ.size() == 0) begin
         check("out_valid_idle", 64'(out_valid_o), 64'd0);
      end else if (out_valid_o) begin
         e = expQ[0];
         check("out_cos", 64'(out_cos_o), 64'(e.c));
         check("out_sin", 64'(out_sin_o), 64'(e.s));
         check("out_point", 64'(out_point_o), 64'(e.idx % P));
         check("out_frame", 64'(out_frame_o), 64'(e.idx / P));
         check("out_last", 64'(out_last_o), 64'(e.idx == TOTAL - 1));
         if (out_ready_i) begin
            void'(expQ.pop_front());
            outCnt++;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      thetaCos_valid_i = 1'b0;
      thetaSin_valid_i = 1'b0;
      if (cosQ.size() != 0 && cosQ[0].t == cyc) begin
         thetaCos_valid_i = 1'b1;
         thetaCos_i       = cosQ[0].v;
         void'(cosQ.pop_front());
      end
      if (sinQ.size() != 0 && sinQ[0].t == cyc) begin
         thetaSin_valid_i = 1'b1;
         thetaSin_i       = sinQ[0].v;
         void'(sinQ.pop_front());
      end
   endtask

   task automatic doReset();
      rst_i   = 1'b1;
      start_i = 1'b0;
      abort_i = 1'b0;
      tick();
      cosQ.delete();
      sinQ.delete();
      expQ.delete();
      tick();
      check("reset_outputs",
            64'({theta_iteration_o, out_valid_o, out_cos_o, out_sin_o, out_point_o,
                 out_frame_o, out_last_o, busy_o, done_o, err_o}), 64'd0);
      rst_i = 1'b0;
      cosQ.delete();
      sinQ.delete();
      expQ.delete();
      thetaCos_valid_i = 1'b0;
      thetaSin_valid_i = 1'b0;
      lastDone = cyc;
   endtask

   task automatic startScan(input int m);
      mode     = m;
      reqIdx   = 0;
      pulseCnt = 0;
      outCnt   = 0;
      doneCnt  = 0;
      lastDone = cyc;
      start_i  = 1'b1;
      tick();
      start_i  = 1'b0;
   endtask

   task automatic waitIdle(input string pfx, input int bound);
      for (int i = 0; i < bound && busy_o; i++) tick();
      check({pfx, "_idle"}, 64'(busy_o), 64'd0);
   endtask

   task automatic scanCounts(input string pfx, input int pulses, input int outs, input int dones);
      check({pfx, "_pulses"}, 64'(pulseCnt), 64'(pulses));
      check({pfx, "_outputs"}, 64'(outCnt), 64'(outs));
      check({pfx, "_done"}, 64'(doneCnt), 64'(dones));
      check({pfx, "_err"}, 64'(err_o), 64'd0);
      check({pfx, "_leftover"}, 64'(expQ.size()), 64'd0);
   endtask

   initial begin
      checks = 0; failures = 0; cyc = 0; mode = 0; reqIdx = 0; lastDone = 0;
      pulseCnt = 0; outCnt = 0; doneCnt = 0;
      rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; out_ready_i = 1'b1;
      thetaCos_valid_i = 1'b0; thetaSin_valid_i = 1'b0;
      thetaCos_i = '0; thetaSin_i = '0;
      doReset();

      // Nominal scan, results return together three cycles after each pulse.
      startScan(0);
      waitIdle("nominal", 100);
      scanCounts("nominal", TOTAL, TOTAL, 1);

      // Output stalled: issue must stop at the credit limit and the head must hold.
      out_ready_i = 1'b0;
      startScan(0);
      repeat (20) tick();
      check("stall_pulses", 64'(pulseCnt), 64'(D));
      check("stall_valid", 64'(out_valid_o), 64'd1);
      out_ready_i = 1'b1;
      waitIdle("stall", 100);
      scanCounts("stall", TOTAL, TOTAL, 1);

      // Cos arrives two cycles ahead of sin; first pair is {1234,5678}.
      startScan(2);
      waitIdle("split", 200);
      scanCounts("split", TOTAL, TOTAL, 1);

      // Random return timing and random downstream readiness.
      for (int k = 0; k < 3; k++) begin
         startScan(1);
         for (int i = 0; i < 400 && busy_o; i++) begin
            out_ready_i = 1'($urandom_range(1, 0));
            tick();
         end
         out_ready_i = 1'b1;
         waitIdle("rand", 50);
         scanCounts("rand", TOTAL, TOTAL, 1);
      end

      // Abort with two results queued and two requests in flight.
      out_ready_i = 1'b0;
      startScan(0);
      repeat (5) tick();
      check("abort_pre_valid", 64'(out_valid_o), 64'd1);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      expQ.delete();
      check("abort_valid", 64'(out_valid_o), 64'd0);
      check("abort_busy", 64'(busy_o), 64'd1);
      out_ready_i = 1'b1;
      waitIdle("abort", 50);
      scanCounts("abort", D, 0, 0);

      // Protocol errors: stray sin in IDLE, then back-to-back cos with one pending.
      sinQ.push_back('{cyc + 1, 16'h00AA});
      tick();
      tick();
      check("err_idle_sin", 64'(err_o), 64'd1);
      doReset();
      startScan(3);
      cosQ.push_back('{cyc + 1, 16'h0011});
      cosQ.push_back('{cyc + 2, 16'h0022});
      tick();
      tick();
      check("err_first_cos_ok", 64'(err_o), 64'd0);
      tick();
      check("err_dup_cos", 64'(err_o), 64'd1);
      repeat (5) tick();
      check("err_sticky", 64'(err_o), 64'd1);
      doReset();

      // Reset mid-run, then a clean restart from point 0 / frame 0.
      startScan(1);
      repeat (6) tick();
      doReset();
      startScan(0);
      waitIdle("restart", 100);
      scanCounts("restart", TOTAL, TOTAL, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
